// File: rtl/fp_mult_pkg.sv
// ============================================================================
// fp_mult_pkg : bus addresses, status codes and FSM states shared by the
//               bfloat16 multiplier sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_mult_pkg;

   localparam logic [2:0]  ADDR_OP1    = 3'd0;
   localparam logic [2:0]  ADDR_OP2    = 3'd1;
   localparam logic [2:0]  ADDR_S      = 3'd2;
   localparam logic [2:0]  ADDR_RESULT = 3'd3;
   localparam logic [2:0]  ADDR_STATUS = 3'd4;

   localparam logic [15:0] QNAN16      = 16'h7FC0;
   localparam logic [15:0] START_CMD   = 16'h0001;

   typedef enum logic [2:0] {
      ST_OK      = 3'd0,
      ST_OVF     = 3'd1,
      ST_UNF     = 3'd2,
      ST_ZERO    = 3'd3,
      ST_NAN     = 3'd4,
      ST_TIMEOUT = 3'd7
   } fp_status_e;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_OP1   = 3'd1,
      S_WR_OP2   = 3'd2,
      S_WR_START = 3'd3,
      S_RD_RES   = 3'd4,
      S_RD_STAT  = 3'd5,
      S_OUT      = 3'd6
   } seq_state_e;

   // States in which a request is outstanding on the Avalon bus
   function automatic logic is_bus_phase(input seq_state_e s);
      return (s == S_WR_OP1) || (s == S_WR_OP2) || (s == S_WR_START) ||
             (s == S_RD_RES) || (s == S_RD_STAT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mult_seq_master_wait_watchdog.sv
// ============================================================================
// wait_watchdog : counts consecutive stalled bus cycles and flags the cycle
//                 in which the stall budget runs out
// Rev 1.0
// ============================================================================
`default_nettype none

module wait_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Fires during the last permitted stall cycle, so the caller can drop
   // its request on the following edge.
   assign expired = tick && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || expired) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fp_mult_seq_master.sv
// ============================================================================
// fp_mult_seq_master : Avalon-MM master that runs one bfloat16 multiply per
//                      accepted operand pair and streams out {result,status}
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_mult_seq_master
   import fp_mult_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_result,
   output logic [2:0]       out_status,
   output logic [2:0]       avm_address,
   output logic             avm_read,
   output logic             avm_write,
   output logic [15:0]      avm_writedata,
   input  logic [15:0]      avm_readdata,
   input  logic             avm_waitrequest,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   seq_state_e       state_q,     state_d;
   logic [15:0]      b_q,         b_d;
   logic [2:0]       addr_q,      addr_d;
   logic             rd_q,        rd_d;
   logic             wr_q,        wr_d;
   logic [15:0]      wdata_q,     wdata_d;
   logic             ovalid_q,    ovalid_d;
   logic [15:0]      result_q,    result_d;
   logic [2:0]       status_q,    status_d;
   logic [CNT_W-1:0] ops_q,       ops_d;

   logic bus_phase;
   logic wd_tick;
   logic wd_clear;
   logic wd_expired;

   assign bus_phase = is_bus_phase(state_q);
   assign wd_tick   = bus_phase && avm_waitrequest;
   assign wd_clear  = !bus_phase || !avm_waitrequest;

   wait_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .tick    (wd_tick),
      .expired (wd_expired)
   );

   always_comb begin
      state_d  = state_q;
      b_d      = b_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      ovalid_d = ovalid_q;
      result_d = result_q;
      status_d = status_q;
      ops_d    = ops_q;

      // Each phase preloads the next phase's request so the bus signals
      // come straight from flops and stay put while the slave stalls.
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               b_d     = in_b;
               wr_d    = 1'b1;
               addr_d  = ADDR_OP1;
               wdata_d = in_a;
               state_d = S_WR_OP1;
            end
         end
         S_WR_OP1: begin
            if (!avm_waitrequest) begin
               addr_d  = ADDR_OP2;
               wdata_d = b_q;
               state_d = S_WR_OP2;
            end
         end
         S_WR_OP2: begin
            if (!avm_waitrequest) begin
               addr_d  = ADDR_S;
               wdata_d = START_CMD;
               state_d = S_WR_START;
            end
         end
         S_WR_START: begin
            if (!avm_waitrequest) begin
               wr_d    = 1'b0;
               rd_d    = 1'b1;
               addr_d  = ADDR_RESULT;
               state_d = S_RD_RES;
            end
         end
         S_RD_RES: begin
            if (!avm_waitrequest) begin
               result_d = avm_readdata;
               addr_d   = ADDR_STATUS;
               state_d  = S_RD_STAT;
            end
         end
         S_RD_STAT: begin
            if (!avm_waitrequest) begin
               status_d = avm_readdata[2:0];
               rd_d     = 1'b0;
               ovalid_d = 1'b1;
               state_d  = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               ops_d    = ops_q + CNT_W'(1);
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A stalled slave ends the operation with a quiet-NaN tagged result
      if (bus_phase && wd_expired) begin
         rd_d     = 1'b0;
         wr_d     = 1'b0;
         result_d = QNAN16;
         status_d = ST_TIMEOUT;
         ovalid_d = 1'b1;
         state_d  = S_OUT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         b_q      <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         ovalid_q <= 1'b0;
         result_q <= '0;
         status_q <= '0;
         ops_q    <= '0;
      end else begin
         state_q  <= state_d;
         b_q      <= b_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         ovalid_q <= ovalid_d;
         result_q <= result_d;
         status_q <= status_d;
         ops_q    <= ops_d;
      end
   end

   assign in_ready      = !reset && (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign avm_address   = addr_q;
   assign avm_read      = rd_q;
   assign avm_write     = wr_q;
   assign avm_writedata = wdata_q;
   assign out_valid     = ovalid_q;
   assign out_result    = result_q;
   assign out_status    = status_q;
   assign ops_done      = ops_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_seq_master.sv
// ============================================================================
// tb_fp_mult_seq_master : directed bench with a stallable multiplier slave
//                         model and a permanently stalling stub slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_mult_seq_master;
   import fp_mult_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main DUT against the multiplier slave model
   logic        in_valid, in_ready, out_valid, out_ready, avm_read, avm_write, avm_wait, busy;
   logic [15:0] in_a, in_b, out_result, avm_wdata, avm_rdata, ops_done;
   logic [2:0]  out_status, avm_addr;

   // Second DUT against a slave that never releases waitrequest
   logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_read, t_write, t_busy;
   logic [15:0] t_in_a, t_in_b, t_result, t_wdata;
   logic [2:0]  t_status, t_addr;
   logic [1:0]  t_ops;

   fp_mult_seq_master #(.TIMEOUT_CYCLES(64), .CNT_W(16)) u_dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_status(out_status),
      .avm_address(avm_addr), .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_wdata),
      .avm_readdata(avm_rdata), .avm_waitrequest(avm_wait), .busy(busy), .ops_done(ops_done));

   fp_mult_seq_master #(.TIMEOUT_CYCLES(8), .CNT_W(2)) u_to (
      .clk(clk), .reset(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(t_in_a), .in_b(t_in_b),
      .out_valid(t_out_valid), .out_ready(t_out_ready), .out_result(t_result), .out_status(t_status),
      .avm_address(t_addr), .avm_read(t_read), .avm_write(t_write), .avm_writedata(t_wdata),
      .avm_readdata(16'h0000), .avm_waitrequest(1'b1), .busy(t_busy), .ops_done(t_ops));

   // ---------------- multiplier slave model ----------------
   function automatic logic [18:0] bf_mul(input logic [15:0] x, input logic [15:0] y);
      logic        s;
      logic [15:0] p;
      int          e;
      s = x[15] ^ y[15];
      if ((x[14:7] == 8'hFF && x[6:0] != 7'd0) || (y[14:7] == 8'hFF && y[6:0] != 7'd0))
         return {3'd4, 16'h7FC0};
      if (x[14:0] == 15'd0 || y[14:0] == 15'd0)
         return {3'd3, 16'h0000};
      p = {8'd0, 1'b1, x[6:0]} * {8'd0, 1'b1, y[6:0]};
      e = int'(x[14:7]) + int'(y[14:7]) - 127 + int'(p[15]);
      if (e >= 255) return {3'd1, s, 8'hFF, 7'd0};
      if (e <= 0)   return {3'd2, s, 15'd0};
      return {3'd0, s, e[7:0], (p[15] ? p[14:8] : p[13:7])};
   endfunction

   logic [15:0] s_op1, s_op2, s_res, s_last_s;
   logic [2:0]  s_stat;
   int          s_stall, s_lim, proto_err;
   logic        p_pend, p_rd, p_wr;
   logic [2:0]  p_addr;
   logic [15:0] p_wdata;

   assign avm_wait  = avm_read && (avm_addr == ADDR_RESULT) && (s_stall < s_lim);
   assign avm_rdata = (avm_addr == ADDR_RESULT) ? s_res : {13'd0, s_stat};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s_op1 <= '0; s_op2 <= '0; s_res <= '0; s_stat <= '0; s_last_s <= '0;
         s_stall <= 0; p_pend <= 1'b0; p_rd <= 1'b0; p_wr <= 1'b0; p_addr <= '0; p_wdata <= '0;
      end else begin
         s_stall <= avm_wait ? s_stall + 1 : 0;
         if (avm_write && !avm_wait) begin
            case (avm_addr)
               ADDR_OP1: s_op1 <= avm_wdata;
               ADDR_OP2: s_op2 <= avm_wdata;
               ADDR_S: begin
                  s_last_s <= avm_wdata;
                  if (avm_wdata[0]) {s_stat, s_res} <= bf_mul(s_op1, s_op2);
               end
               default: ;
            endcase
         end
         if (avm_read && avm_write) proto_err <= proto_err + 1;
         if (p_pend && {avm_read, avm_write, avm_addr, avm_wdata} != {p_rd, p_wr, p_addr, p_wdata})
            proto_err <= proto_err + 1;
         p_pend <= (avm_read || avm_write) && avm_wait;
         p_rd <= avm_read; p_wr <= avm_write; p_addr <= avm_addr; p_wdata <= avm_wdata;
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;
   int exp_ops = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic [2:0] st, output int lat);
      int n;
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
      res = out_result; st = out_status;
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(output logic [15:0] res, output logic [2:0] st, output int lat,
                         output logic [3:0] first_bus, output logic [1:0] rw_at_out);
      int n;
      @(negedge clk);
      t_in_a = 16'h3F80; t_in_b = 16'h4000; t_in_valid = 1'b1;
      n = 0;
      while (!t_in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 t_in_valid = 1'b0;
      lat = 0; first_bus = '0;
      do begin
         @(negedge clk); lat++;
         if (lat == 1) first_bus = {t_write, t_addr};
      end while (!t_out_valid && lat < 200);
      res = t_result; st = t_status; rw_at_out = {t_read, t_write};
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] a, b, res, mask;
      logic [2:0]  st;
      int          lim, lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [15:0] r, r0;
      logic [2:0]  st;
      logic [3:0]  fb;
      logic [1:0]  rw;
      int          lat, n, bad;

      vecs[0] = '{16'h3F80, 16'h4000, 16'h4000, 16'hFFFF, 3'd0, 3, 9};
      vecs[1] = '{16'h0000, 16'h4000, 16'h0000, 16'hFFFF, 3'd3, 3, 9};
      vecs[2] = '{16'h7F7F, 16'h7F7F, 16'h7F80, 16'hFFFF, 3'd1, 3, 9};
      vecs[3] = '{16'h7FC1, 16'h3F80, 16'h7F80, 16'h7F80, 3'd4, 3, 9};
      vecs[4] = '{16'h4080, 16'h4080, 16'h4180, 16'hFFFF, 3'd0, 3, 9};
      vecs[5] = '{16'hC000, 16'h4000, 16'hC080, 16'hFFFF, 3'd0, 3, 9};
      vecs[6] = '{16'h0080, 16'h0080, 16'h0000, 16'hFFFF, 3'd2, 3, 9};
      vecs[7] = '{16'h3FC0, 16'h3FC0, 16'h4010, 16'hFFFF, 3'd0, 3, 9};
      vecs[8] = '{16'h3F80, 16'h4000, 16'h4000, 16'hFFFF, 3'd0, 0, 6};

      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      t_in_valid = 1'b0; t_in_a = '0; t_in_b = '0; t_out_ready = 1'b1;
      s_lim = 3; proto_err = 0;

      // Reset values
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({busy, in_ready, out_valid, avm_read, avm_write, avm_addr, out_status}), 32'd0);
      check("reset_data", 32'({avm_wdata, out_result}), 32'd0);
      check("reset_ops", 32'(ops_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      foreach (vecs[i]) begin
         s_lim = vecs[i].lim;
         run_op(vecs[i].a, vecs[i].b, r, st, lat);
         exp_ops++;
         check($sformatf("v%0d_result", i), 32'(r & vecs[i].mask), 32'(vecs[i].res));
         check($sformatf("v%0d_status", i), 32'(st), 32'(vecs[i].st));
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_wr_ops", i), {s_op1, s_op2}, {vecs[i].a, vecs[i].b});
         check($sformatf("v%0d_wr_start", i), 32'(s_last_s), 32'h1);
         check($sformatf("v%0d_ops_done", i), 32'(ops_done), 32'(exp_ops));
      end
      s_lim = 3;

      // Back-pressure with a second pair waiting on in_valid
      out_ready = 1'b0;
      @(negedge clk);
      in_a = 16'h3F80; in_b = 16'h4000; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 in_a = 16'h4000; in_b = 16'h4000;
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 200);
      r0 = out_result;
      check("bp_first_result", 32'(r0), 32'h4000);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_result !== 16'h4000 || out_status !== 3'd0 || in_ready !== 1'b0 ||
             out_valid !== 1'b1 || ops_done !== 16'(exp_ops)) bad++;
      end
      check("bp_hold_cycles_bad", 32'(bad), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      exp_ops++;
      @(negedge clk);
      check("bp_after_handoff_idle", 32'({in_ready, busy, ops_done}), 32'({1'b1, 1'b0, 16'(exp_ops)}));
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 200);
      check("bp_second_result", 32'({out_status, out_result}), 32'({3'd0, 16'h4080}));
      check("bp_second_op1", 32'(s_op1), 32'h4000);
      @(posedge clk);
      exp_ops++;
      #1;

      // Reset while the result read is stalled
      @(negedge clk);
      in_a = 16'h4080; in_b = 16'h4080; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!(avm_read && avm_addr == ADDR_RESULT) && n < 50) begin @(negedge clk); n++; end
      check("mid_reset_reached_rd_res", 32'(n < 50), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_reset_outputs", 32'({busy, in_ready, out_valid, avm_read, avm_write, avm_addr, out_status}), 32'd0);
      check("mid_reset_data", 32'({avm_wdata, out_result}), 32'd0);
      check("mid_reset_ops", 32'(ops_done), 32'd0);
      exp_ops = 0;
      @(negedge clk);
      rst = 1'b0;
      run_op(16'h3FC0, 16'h3FC0, r, st, lat);
      exp_ops++;
      check("post_reset_result", 32'({st, r}), 32'({3'd0, 16'h4010}));
      check("post_reset_latency", 32'(lat), 32'd9);
      check("post_reset_ops", 32'(ops_done), 32'(exp_ops));

      // Watchdog abort against a permanently stalling slave; 2-bit counter wraps
      for (int k = 1; k <= 4; k++) begin
         run_to(r, st, lat, fb, rw);
         check($sformatf("to%0d_result", k), 32'({st, r}), 32'({3'd7, 16'h7FC0}));
         check($sformatf("to%0d_latency", k), 32'(lat), 32'd9);
         check($sformatf("to%0d_first_write", k), 32'(fb), 32'b1000);
         check($sformatf("to%0d_bus_released", k), 32'(rw), 32'd0);
         check($sformatf("to%0d_ops_done", k), 32'(t_ops), 32'(k % 4));
      end

      check("protocol_violations", 32'(proto_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
